serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/adder2_slice.sv | 12 +
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder
package serial_add_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pair counter width, never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
    endfunction

endpackage

// File: rtl/adder2_slice.sv
// rtl/adder2_slice.sv - combinational 2-bit full-adder slice
module adder2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c_in,
    output logic [1:0] s,
    output logic       c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {2'b00, c_in};

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - serial adder, two bits per cycle, IDLE/RUN/DONE control
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int PAIRS = WIDTH / SLICE_W;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic [WIDTH-1:0]   res_next;
    logic               last_pair;

    adder2_slice u_slice (
        .a     (a_q[SLICE_W-1:0]),
        .b     (b_q[SLICE_W-1:0]),
        .c_in  (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // Slice sum enters at the MSB so pair 0 ends up in the LSBs after the last step
    assign res_next  = (res_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
    assign last_pair = (cnt_q == LAST_PAIR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_pair) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = slice_c;
                res_d   = res_next;
                if (last_pair) begin
                    sum_d  = res_next;
                    cout_d = slice_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    cnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
